// File: rtl/clk_div_cfg_ctrl.sv
// Reconfiguration sequencer for the programmable clock divider: arbitrates ratio-change
// requests and applies them glitch-free. Optional macro CLK_DIV_CFG_TIMEOUT_FLAG_EN adds a sticky timeout flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no change in flight; arbitrate pending requests
// CHECK     | compare latched ratio with current, pick the path
// WAIT_EDGE | divider running; wait for its falling edge (or timeout)
// GATE      | clock enable held low for GATE_CYC cycles
// LOAD      | drive the new ratio onto the divider
// ENABLE    | re-enable the divider
// SETTLE    | let the divider settle for SETTLE_CYC cycles
// ACK       | pulse the ack to the granted requester
`timescale 1ns/1ps
module clk_div_cfg_ctrl #(
    parameter int unsigned INT_WIDTH   = 8,
    parameter int unsigned RST_RATIO   = 1,
    parameter int unsigned GATE_CYC    = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    input  logic [INT_WIDTH-1:0] i_req_ratio0,
    input  logic [INT_WIDTH-1:0] i_req_ratio1,
    output logic [1:0]           o_req_ack,
    input  logic                 i_div_clk,
    output logic                 o_clk_en,
    output logic [INT_WIDTH-1:0] o_div_ratio,
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
    input  logic                 i_err_clr,
    output logic                 o_timeout_err,
`endif
    output logic                 o_busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] GATE_LD    = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [INT_WIDTH-1:0] RATIO_RST = INT_WIDTH'(RST_RATIO);
    localparam logic [INT_WIDTH-1:0] RATIO_MIN = INT_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_EDGE,
        GATE,
        LOAD,
        ENABLE,
        SETTLE,
        ACK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rr_q, rr_d;
    logic                 gnt_idx_q, gnt_idx_d;
    logic [INT_WIDTH-1:0] new_ratio_q, new_ratio_d;
    logic [INT_WIDTH-1:0] ratio_q, ratio_d;
    logic                 clk_en_q, clk_en_d;
    logic [1:0]           ack_q, ack_d;
    logic                 div_clk_q;
    logic                 fall_edge;
    logic                 gnt_sel;

    assign fall_edge = div_clk_q & ~i_div_clk;
    assign gnt_sel   = (&i_req_valid) ? rr_q : i_req_valid[1];

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            gnt_idx_q   <= 1'b0;
            new_ratio_q <= '0;
            ratio_q     <= RATIO_RST;
            clk_en_q    <= 1'b0;
            ack_q       <= '0;
            div_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            gnt_idx_q   <= gnt_idx_d;
            new_ratio_q <= new_ratio_d;
            ratio_q     <= ratio_d;
            clk_en_q    <= clk_en_d;
            ack_q       <= ack_d;
            div_clk_q   <= i_div_clk;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        gnt_idx_d   = gnt_idx_q;
        new_ratio_d = new_ratio_q;
        ratio_d     = ratio_q;
        clk_en_d    = clk_en_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    gnt_idx_d   = gnt_sel;
                    new_ratio_d = gnt_sel ? i_req_ratio1 : i_req_ratio0;
                    rr_d        = ~gnt_sel;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (new_ratio_q == ratio_q) begin
                    state_d = ACK;
                end else if (!clk_en_q) begin
                    state_d  = GATE;
                    cnt_d    = GATE_LD;
                    clk_en_d = 1'b0;
                end else begin
                    state_d = WAIT_EDGE;
                    cnt_d   = TIMEOUT_LD;
                end
            end
            WAIT_EDGE: begin
                // a timeout still gates: the divider is assumed stuck, not mid-pulse
                if (fall_edge || (cnt_q == '0)) begin
                    state_d  = GATE;
                    cnt_d    = GATE_LD;
                    clk_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                ratio_d = new_ratio_q;
                if (new_ratio_q >= RATIO_MIN) begin
                    state_d  = ENABLE;
                    clk_en_d = 1'b1;
                end else begin
                    state_d = ACK;
                end
            end
            ENABLE: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LD;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                ack_d   = gnt_idx_q ? 2'b10 : 2'b01;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy      = (state_q != IDLE);
        o_clk_en    = clk_en_q;
        o_div_ratio = ratio_q;
        o_req_ack   = ack_q;
    end

`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
    logic err_q, err_d;
    logic timeout_ev;

    assign timeout_ev = (state_q == WAIT_EDGE) && !fall_edge && (cnt_q == '0);

    always_comb begin
        err_d = err_q;
        if (timeout_ev) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_timeout_err = err_q;
`endif

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Randomized self-checking bench for clk_div_cfg_ctrl against a transaction-level model
// of arbitration order, latency bounds and final divider settings, plus a behavioural divider.
`timescale 1ns/1ps
module tb_clk_div_cfg_ctrl;
    localparam int GATE_CYC    = 2;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int RST_RATIO   = 1;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_req_valid;
    logic [7:0] i_req_ratio0, i_req_ratio1;
    logic [1:0] o_req_ack;
    logic       i_div_clk;
    logic       o_clk_en;
    logic [7:0] o_div_ratio;
    logic       o_busy;
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
    logic       i_err_clr;
    logic       o_timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;
    int div_cnt  = 0;
    bit div_prev = 1'b0;
    bit en_last  = 1'b0;
    int ratio_last = RST_RATIO;
    bit stuck    = 1'b0;

    int m_ratio, m_ptr;
    bit m_en, m_err;

    clk_div_cfg_ctrl #(
        .INT_WIDTH(8), .RST_RATIO(RST_RATIO), .GATE_CYC(GATE_CYC),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_ratio0(i_req_ratio0),
        .i_req_ratio1(i_req_ratio1),
        .o_req_ack   (o_req_ack),
        .i_div_clk   (i_div_clk),
        .o_clk_en    (o_clk_en),
        .o_div_ratio (o_div_ratio),
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
        .i_err_clr   (i_err_clr),
        .o_timeout_err(o_timeout_err),
`endif
        .o_busy      (o_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural divider plus glitch monitor, evaluated just after each rising edge.
    initial begin
        i_div_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!i_rst) begin
                if (en_last && !o_clk_en && !stuck && !(div_prev && !i_div_clk)) viol++;
                if (en_last && int'(o_div_ratio) != ratio_last) viol++;
            end
            div_prev   = i_div_clk;
            en_last    = o_clk_en;
            ratio_last = int'(o_div_ratio);
            if (stuck) begin
                i_div_clk = 1'b1;
            end else if (!o_clk_en || o_div_ratio < 8'd2) begin
                div_cnt   = 0;
                i_div_clk = 1'b0;
            end else begin
                div_cnt   = (div_cnt + 1) % int'(o_div_ratio);
                i_div_clk = (div_cnt < int'(o_div_ratio) / 2);
            end
        end
    end

    // Issue a request pattern at a falling edge and follow every grant to its ack.
    task automatic run_txn(input logic [1:0] mask, input logic [7:0] ra0, input logic [7:0] ra1);
        logic [1:0] pending;
        int w, r, lo, hi, tail, n;
        bit exp_en;
        chk("idle_before_req", 32'(o_busy), 32'd0);
        i_req_ratio0 = ra0;
        i_req_ratio1 = ra1;
        i_req_valid  = mask;
        pending      = mask;
        while (pending != 2'b00) begin
            w     = (pending == 2'b11) ? m_ptr : (pending[1] ? 1 : 0);
            m_ptr = 1 - w;
            r     = w ? int'(ra1) : int'(ra0);
            tail  = 3 + GATE_CYC + ((r >= 2) ? 1 + SETTLE_CYC : 0);
            if (r == m_ratio) begin
                lo = 2; hi = 2; exp_en = m_en;
            end else begin
                exp_en = (r >= 2);
                if (!m_en) begin
                    lo = tail; hi = tail;
                end else if (stuck) begin
                    lo = tail + TIMEOUT_CYC; hi = lo; m_err = 1'b1;
                end else begin
                    lo = tail + 1; hi = tail + m_ratio + 2;
                end
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) chk("busy_after_grant", 32'(o_busy), 32'd1);
                if (n == 5 && r != m_ratio && !m_en && r >= 2) begin
                    chk("ratio_at_load", 32'(o_div_ratio), 32'(r));
                    chk("en_at_load", 32'(o_clk_en), 32'd1);
                end
            end while (o_req_ack == 2'b00 && n <= hi + 4);
            chk("ack_grantee", 32'(o_req_ack), 32'(1) << w);
            chk("latency_in_range", 32'((n - 1 >= lo) && (n - 1 <= hi)), 32'd1);
            if (lo == hi) chk("latency_exact", 32'(n - 1), 32'(lo));
            chk("ratio_after", 32'(o_div_ratio), 32'(r));
            chk("en_after", 32'(o_clk_en), 32'(exp_en));
            chk("busy_at_ack", 32'(o_busy), 32'd0);
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
            chk("timeout_flag", 32'(o_timeout_err), 32'(m_err));
`endif
            m_ratio        = r;
            m_en           = exp_en;
            pending[w]     = 1'b0;
            i_req_valid[w] = 1'b0;
        end
        @(negedge clk);
        chk("ack_one_cycle", 32'(o_req_ack), 32'd0);
    endtask

    initial begin
        logic [1:0] mask;
        logic [7:0] ra0, ra1;
        logic [1:0] ack_acc;
        int n;
        i_rst = 1'b1;
        i_req_valid = 2'b00;
        i_req_ratio0 = '0;
        i_req_ratio1 = '0;
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
        i_err_clr = 1'b0;
`endif
        m_ratio = RST_RATIO; m_en = 1'b0; m_ptr = 0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk_en", 32'(o_clk_en), 32'd0);
        chk("rst_ratio", 32'(o_div_ratio), 32'(RST_RATIO));
        chk("rst_ack", 32'(o_req_ack), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
        chk("rst_err", 32'(o_timeout_err), 32'd0);
`endif
        i_rst = 1'b0;
        @(negedge clk);

        run_txn(2'b01, 8'd4, 8'd0);
        repeat (5) @(negedge clk);
        run_txn(2'b10, 8'd0, 8'd3);
        run_txn(2'b11, 8'd2, 8'd5);
        run_txn(2'b11, 8'd3, 8'd6);
        run_txn(2'b10, 8'd0, 8'd6);
        run_txn(2'b01, 8'd1, 8'd0);
        run_txn(2'b01, 8'd4, 8'd0);

        stuck = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(2'b01, 8'd6, 8'd0);
        stuck = 1'b0;
`ifdef CLK_DIV_CFG_TIMEOUT_FLAG_EN
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_cleared", 32'(o_timeout_err), 32'd0);
`endif
        repeat (3) @(negedge clk);

        // reset landing in SETTLE of an enable-low change to ratio 3
        run_txn(2'b01, 8'd1, 8'd0);
        i_req_ratio0 = 8'd3;
        i_req_valid  = 2'b01;
        repeat (7) @(negedge clk);
        chk("pre_rst_en", 32'(o_clk_en), 32'd1);
        chk("pre_rst_ratio", 32'(o_div_ratio), 32'd3);
        i_rst = 1'b1;
        i_req_valid = 2'b00;
        @(negedge clk);
        i_rst = 1'b0;
        chk("midseq_rst_en", 32'(o_clk_en), 32'd0);
        chk("midseq_rst_ratio", 32'(o_div_ratio), 32'(RST_RATIO));
        chk("midseq_rst_busy", 32'(o_busy), 32'd0);
        ack_acc = o_req_ack;
        repeat (12) begin
            @(negedge clk);
            ack_acc |= o_req_ack;
        end
        chk("midseq_rst_no_ack", 32'(ack_acc), 32'd0);
        m_ratio = RST_RATIO; m_en = 1'b0; m_ptr = 0; m_err = 1'b0;

        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            ra0  = 8'($urandom_range(0, 6));
            ra1  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) ra0 = 8'(m_ratio);
            if ($urandom_range(0, 3) == 0) ra1 = 8'(m_ratio);
            run_txn(mask, ra0, ra1);
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
        end

        chk("glitch_free_violations", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
